joypad_responder: RTL and testbench

// - Device-side emulation of a standard NES controller (CD4021-style 8-bit parallel-in/serial-out register).
// - Responds to the latch/clock strobes that rp2a03 drives on jp_latch/jp_clk, returning button state serially on jp_data.
// - Buttons come from board push-buttons, switches or a host bridge; the block loops back into a second console port or drives an external console.

---
 rtl/joypad_responder.sv | 199 +++++++++++++++++++
 tb/tb_joypad_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_responder.sv
// Device-side NES controller (CD4021-style) responder: filtered latch/clk strobes, serial button readout.
// Optional turbo on A/B is compiled in when JOYPAD_TURBO_EN is defined.

module joypad_strobe_filter #(
  parameter int FILTER_LEN = 2,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pin_in,
  output logic rise_out,
  output logic fall_out
);
  localparam logic [3:0] LAST_CNT = 4'(FILTER_LEN - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_filt;
  logic       r_filt_d;
  logic [3:0] r_cnt;

  // Filtered level only moves after the synchronized value has disagreed for FILTER_LEN straight cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1     <= IDLE_LEVEL;
      r_s2     <= IDLE_LEVEL;
      r_filt   <= IDLE_LEVEL;
      r_filt_d <= IDLE_LEVEL;
      r_cnt    <= '0;
    end else begin
      r_s1     <= pin_in;
      r_s2     <= r_s1;
      r_filt_d <= r_filt;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign rise_out = r_filt & ~r_filt_d;
  assign fall_out = ~r_filt & r_filt_d;
endmodule

module joypad_responder #(
  parameter int FILTER_LEN   = 2,
  parameter bit LATCH_INV    = 1'b0,
  parameter int TURBO_PERIOD = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] buttons_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic       poll_out,
  output logic [3:0] bits_read_out,
  input  logic [1:0] turbo_en_in,
  output logic [1:0] dbg_state_out
);
  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_sr;
  logic [7:0] w_sr_nxt;
  logic [3:0] r_bits;
  logic [3:0] w_bits_nxt;
  logic       r_data;
  logic       r_poll;
  logic       w_poll_nxt;
  logic       w_latch_pin;
  logic       w_latch_rise;
  logic       w_latch_fall;
  logic       w_clk_rise;
  logic       w_clk_fall_unused;
  logic [7:0] w_load_val;

  assign w_latch_pin = LATCH_INV ? ~jp_latch_in : jp_latch_in;

  joypad_strobe_filter #(.FILTER_LEN(FILTER_LEN), .IDLE_LEVEL(1'b0)) u_latch_filt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .pin_in   (w_latch_pin),
    .rise_out (w_latch_rise),
    .fall_out (w_latch_fall)
  );

  joypad_strobe_filter #(.FILTER_LEN(FILTER_LEN), .IDLE_LEVEL(1'b1)) u_clk_filt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .pin_in   (jp_clk_in),
    .rise_out (w_clk_rise),
    .fall_out (w_clk_fall_unused)
  );

`ifdef JOYPAD_TURBO_EN
  localparam logic [7:0] TURBO_LAST = 8'(TURBO_PERIOD - 1);

  logic [7:0] r_poll_cnt;
  logic       r_turbo_phase;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_poll_cnt    <= '0;
      r_turbo_phase <= 1'b1;
    end else if (r_poll) begin
      if (r_poll_cnt == TURBO_LAST) begin
        r_poll_cnt    <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_poll_cnt <= r_poll_cnt + 8'd1;
      end
    end
  end

  // A turbo-enabled button only reads as pressed during the pass phase.
  assign w_load_val = {buttons_in[7:2],
                       buttons_in[1] & (~turbo_en_in[1] | r_turbo_phase),
                       buttons_in[0] & (~turbo_en_in[0] | r_turbo_phase)};
`else
  logic w_turbo_unused;
  assign w_turbo_unused = ^{turbo_en_in, 8'(TURBO_PERIOD)};
  assign w_load_val     = buttons_in;
`endif

  // A latch rise overrides everything, including a clock edge in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_bits_nxt  = r_bits;
    w_poll_nxt  = 1'b0;
    if (w_latch_rise) begin
      w_state_nxt = ST_LOAD;
      w_sr_nxt    = w_load_val;
      w_bits_nxt  = 4'd0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          w_bits_nxt = 4'd0;
          if (w_latch_fall) begin
            w_state_nxt = ST_SHIFT;
            w_poll_nxt  = 1'b1;
          end else begin
            w_sr_nxt = w_load_val;
          end
        end
        ST_SHIFT: begin
          if (w_clk_rise) begin
            w_sr_nxt   = {1'b1, r_sr[7:1]};
            w_bits_nxt = r_bits + 4'd1;
            if (r_bits == 4'd7) begin
              w_state_nxt = ST_DRAINED;
            end
          end
        end
        ST_DRAINED: begin
          if (w_clk_rise) begin
            w_sr_nxt = {1'b1, r_sr[7:1]};
          end
        end
        default: begin
          w_state_nxt = ST_SHIFT;
          w_bits_nxt  = 4'd0;
        end
      endcase
    end
  end

  // The pin register is fed from the next shift value so it always equals ~sr[0].
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_SHIFT;
      r_sr    <= 8'h00;
      r_bits  <= 4'd0;
      r_data  <= 1'b1;
      r_poll  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_bits  <= w_bits_nxt;
      r_data  <= ~w_sr_nxt[0];
      r_poll  <= w_poll_nxt;
    end
  end

  assign jp_data_out   = r_data;
  assign poll_out      = r_poll;
  assign bits_read_out = r_bits;
  assign dbg_state_out = r_state;
endmodule

// File: tb/tb_joypad_responder.sv
// Bench for joypad_responder: directed vector table, hand-written corner sequences, random polls vs a serial-stream model.
// Turbo sequence is exercised only when JOYPAD_TURBO_EN is defined.

module tb_joypad_responder;
  localparam int FILTER_LEN   = 2;
  localparam int TURBO_PERIOD = 2;
  localparam int SETTLE       = FILTER_LEN + 6;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] buttons_in;
  logic       jp_latch_in;
  logic       jp_clk_in;
  logic       jp_data_out;
  logic       poll_out;
  logic [3:0] bits_read_out;
  logic [1:0] turbo_en_in;
  logic [1:0] dbg_state_out;

  int n_checks  = 0;
  int n_errors  = 0;
  int poll_seen = 0;

  // {bits_read, pin} expected after each console clock pulse
  logic [4:0] exp_q[$];

  typedef struct {
    logic       latch;
    logic       jclk;
    logic [7:0] btn;
    int         hold;
    logic       exp_data;
    logic [3:0] exp_bits;
  } vec_t;
  vec_t vecs[$];

  joypad_responder #(
    .FILTER_LEN   (FILTER_LEN),
    .LATCH_INV    (1'b0),
    .TURBO_PERIOD (TURBO_PERIOD)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .buttons_in    (buttons_in),
    .jp_latch_in   (jp_latch_in),
    .jp_clk_in     (jp_clk_in),
    .jp_data_out   (jp_data_out),
    .poll_out      (poll_out),
    .bits_read_out (bits_read_out),
    .turbo_en_in   (turbo_en_in),
    .dbg_state_out (dbg_state_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (poll_out === 1'b1) poll_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_out(input string name, input logic exp_data, input logic [3:0] exp_bits);
    check({name, " data"}, {7'd0, jp_data_out}, {7'd0, exp_data});
    check({name, " bits"}, {4'd0, bits_read_out}, {4'd0, exp_bits});
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step(3);
    rst_in = 1'b0;
    step(1);
  endtask

  // driver tasks
  task automatic latch_pulse(input logic [7:0] b, input int hold);
    buttons_in  = b;
    jp_latch_in = 1'b1;
    step(hold);
    jp_latch_in = 1'b0;
    step(SETTLE);
  endtask

  task automatic clk_pulse();
    jp_clk_in = 1'b0;
    step(4);
    jp_clk_in = 1'b1;
    step(SETTLE);
  endtask

  // one complete poll checked against the expected serial stream of the pad
  task automatic run_txn(input logic [7:0] b, input int nclk, input string name);
    int         p0;
    logic [4:0] e;
    p0 = poll_seen;
    latch_pulse(b, $urandom_range(12, FILTER_LEN + 2));
    check({name, " poll"}, 8'(poll_seen - p0), 8'd1);
    check_out({name, " load"}, ~b[0], 4'd0);
    for (int k = 1; k <= nclk; k++) begin
      exp_q.push_back({4'((k > 8) ? 8 : k), (k < 8) ? ~b[k] : 1'b0});
    end
    buttons_in = 8'($urandom);
    while (exp_q.size() > 0) begin
      clk_pulse();
      e = exp_q.pop_front();
      check_out(name, e[0], e[4:1]);
    end
  endtask

  task automatic add_vec(input logic l, input logic c, input logic [7:0] b, input int h,
                         input logic d, input logic [3:0] n);
    vec_t v;
    v.latch = l; v.jclk = c; v.btn = b; v.hold = h; v.exp_data = d; v.exp_bits = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic exp_pin [0:12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int p0;
    logic [7:0] b;

    // buttons 8'h81: 12-cycle latch, then 8 rises and 4 extra rises
    add_vec(1'b1, 1'b1, 8'h81, 12, 1'b0, 4'd0);
    add_vec(1'b0, 1'b1, 8'h81, SETTLE, 1'b0, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      add_vec(1'b0, 1'b0, 8'h81, 4, exp_pin[k-1], 4'((k - 1 > 8) ? 8 : k - 1));
      add_vec(1'b0, 1'b1, 8'h81, SETTLE, exp_pin[k], 4'((k > 8) ? 8 : k));
    end

    rst_in      = 1'b1;
    buttons_in  = 8'h00;
    jp_latch_in = 1'b0;
    jp_clk_in   = 1'b1;
    turbo_en_in = 2'b00;
    do_reset();
    check_out("reset", 1'b1, 4'd0);
    check("reset poll", {7'd0, poll_out}, 8'd0);
    step(SETTLE);
    check("post-reset poll", 8'(poll_seen), 8'd0);
    check_out("post-reset", 1'b1, 4'd0);

    p0 = poll_seen;
    for (int i = 0; i < vecs.size(); i++) begin
      jp_latch_in = vecs[i].latch;
      jp_clk_in   = vecs[i].jclk;
      buttons_in  = vecs[i].btn;
      step(vecs[i].hold);
      check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_bits);
    end
    check("vec polls", 8'(poll_seen - p0), 8'd1);

    // short latch and clock glitches mid-shift are ignored
    b = 8'h5A;
    latch_pulse(b, 8);
    clk_pulse();
    clk_pulse();
    p0 = poll_seen;
    latch_pulse(b, FILTER_LEN - 1);
    check("glitch latch poll", 8'(poll_seen - p0), 8'd0);
    check_out("glitch latch", ~b[2], 4'd2);
    jp_clk_in = 1'b0;
    step(1);
    jp_clk_in = 1'b1;
    step(SETTLE);
    check_out("glitch clk", ~b[2], 4'd2);
    clk_pulse();
    check_out("after glitch", ~b[3], 4'd3);

    // latch held: clock ignored, data tracks buttons with one cycle delay
    buttons_in  = 8'h00;
    jp_latch_in = 1'b1;
    step(SETTLE);
    check_out("hold load", 1'b1, 4'd0);
    buttons_in = 8'h01;
    step(1);
    check_out("hold track", 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      jp_clk_in = 1'b0;
      step(4);
      jp_clk_in = 1'b1;
      step(4);
    end
    check_out("hold clk", 1'b0, 4'd0);
    p0 = poll_seen;
    jp_latch_in = 1'b0;
    step(SETTLE);
    check("hold poll", 8'(poll_seen - p0), 8'd1);
    check_out("hold release", 1'b0, 4'd0);
    clk_pulse();
    check_out("hold shift", 1'b1, 4'd1);

    // latch rise coincident with clock rise: load wins
    b = 8'h3D;
    latch_pulse(b, 8);
    clk_pulse();
    check_out("simul pre", ~b[1], 4'd1);
    jp_clk_in = 1'b0;
    step(4);
    jp_latch_in = 1'b1;
    jp_clk_in   = 1'b1;
    step(SETTLE);
    check_out("simul load", ~b[0], 4'd0);
    jp_latch_in = 1'b0;
    step(SETTLE);
    check_out("simul release", ~b[0], 4'd0);

    // reset mid-shift
    b = 8'hC3;
    latch_pulse(b, 8);
    for (int i = 0; i < 3; i++) clk_pulse();
    check_out("pre-rst", ~b[3], 4'd3);
    rst_in = 1'b1;
    step(1);
    rst_in = 1'b0;
    check_out("mid rst", 1'b1, 4'd0);
    run_txn(8'hA5, 9, "after rst");

    // random polls against the serial-stream model
    for (int t = 0; t < 16; t++) begin
      run_txn(8'($urandom), $urandom_range(12, 0), $sformatf("rnd%0d", t));
    end

`ifdef JOYPAD_TURBO_EN
    do_reset();
    turbo_en_in = 2'b01;
    for (int i = 0; i < 8; i++) begin
      latch_pulse(8'h01, 8);
      check_out($sformatf("turbo%0d", i), ((i / TURBO_PERIOD) % 2 == 0) ? 1'b0 : 1'b1, 4'd0);
    end
    turbo_en_in = 2'b00;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
